uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/uart_cmd_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver feeding a 4-byte command-frame parser (header, data hi, data lo, checksum)
// with a ready/valid command output and single-cycle error pulses.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQUENCY = 400000000,
    parameter int unsigned BAUD_RATE     = 57600,
    parameter int unsigned NUM_INPUTS    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [3:0]  cmd_chan,
    output logic [13:0] cmd_data,
    output logic        err_frame,
    output logic        err_csum,
    output logic        err_chan,
    output logic        err_overrun
);
    localparam int unsigned DIV_RAW = CLK_FREQUENCY / (BAUD_RATE * 16);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_DHI, P_DLO, P_CSUM} p_state_t;

    rx_state_t        rx_state, rx_next;
    p_state_t         p_state, p_next;
    logic             rx_s1, rx_s2, rx_prev, armed;
    logic [1:0]       warm;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       tcnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             byte_vld;
    logic [6:0]       hdr, dhi, dlo;
    logic             tick_c, fall_c, sample_c, byte_done_c, stop_bad_c;
    logic             hdr_c, data_c, last_c, csum_ok_c, chan_ok_c, good_c, load_c;

    // Synchronizer; armed only once a real (post-reset) high level has been seen on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
            warm    <= '0;
            armed   <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            warm    <= {warm[0], 1'b1};
            armed   <= armed | (warm[1] & rx_s2);
        end
    end

    assign fall_c = armed & rx_prev & ~rx_s2;
    assign tick_c = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= R_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            R_IDLE:  if (fall_c)   rx_next = R_START;
            R_START: if (sample_c) rx_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (sample_c && bit_idx == 3'd7) rx_next = R_STOP;
            R_STOP:  if (sample_c) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Start bit is checked mid-bit (8 ticks); later bits every 16 ticks from there.
    always_comb begin
        sample_c    = 1'b0;
        byte_done_c = 1'b0;
        stop_bad_c  = 1'b0;
        unique case (rx_state)
            R_START:        sample_c = tick_c && (tcnt == 4'd7);
            R_DATA, R_STOP: sample_c = tick_c && (tcnt == 4'd15);
            default:        sample_c = 1'b0;
        endcase
        if (rx_state == R_STOP && sample_c) begin
            byte_done_c = rx_s2;
            stop_bad_c  = ~rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            byte_vld  <= byte_done_c;
            err_frame <= stop_bad_c;
            if (rx_state == R_IDLE || sample_c) tcnt <= '0;
            else if (tick_c)                    tcnt <= tcnt + 4'd1;
            if (rx_state == R_START)                 bit_idx <= '0;
            else if (rx_state == R_DATA && sample_c) bit_idx <= bit_idx + 3'd1;
            if (rx_state == R_DATA && sample_c) shreg <= {rx_s2, shreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) p_state <= P_HDR;
        else        p_state <= p_next;
    end

    // A header byte restarts the frame from any state; a framing error drops the frame.
    always_comb begin
        p_next = p_state;
        if (err_frame) begin
            p_next = P_HDR;
        end else if (hdr_c) begin
            p_next = P_DHI;
        end else if (data_c) begin
            unique case (p_state)
                P_HDR:   p_next = P_HDR;
                P_DHI:   p_next = P_DLO;
                P_DLO:   p_next = P_CSUM;
                default: p_next = P_HDR;
            endcase
        end
    end

    always_comb begin
        hdr_c     = byte_vld & shreg[7];
        data_c    = byte_vld & ~shreg[7];
        last_c    = data_c && (p_state == P_CSUM);
        csum_ok_c = (shreg[6:0] == (hdr ^ dhi ^ dlo));
        chan_ok_c = (32'(hdr[3:0]) < NUM_INPUTS);
        good_c    = last_c & csum_ok_c & chan_ok_c;
        load_c    = good_c & (~cmd_valid | cmd_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr <= '0;
            dhi <= '0;
            dlo <= '0;
        end else begin
            if (hdr_c)                          hdr <= shreg[6:0];
            if (data_c && p_state == P_DHI)     dhi <= shreg[6:0];
            if (data_c && p_state == P_DLO)     dlo <= shreg[6:0];
        end
    end

    // A new frame may replace the pending command only in the cycle it is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            cmd_chan    <= '0;
            cmd_data    <= '0;
            err_csum    <= 1'b0;
            err_chan    <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_csum    <= last_c & ~csum_ok_c;
            err_chan    <= last_c & csum_ok_c & ~chan_ok_c;
            err_overrun <= good_c & cmd_valid & ~cmd_ready;
            if (load_c) begin
                cmd_valid <= 1'b1;
                cmd_op    <= hdr[6:4];
                cmd_chan  <= hdr[3:0];
                cmd_data  <= {dhi, dlo};
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Randomized bench for uart_cmd_rx: a byte-stream reference model fills expectation queues,
// a negedge monitor pops them whenever the DUT reports a command or an error pulse.
module tb_uart_cmd_rx;
    localparam int unsigned CLK_HZ  = 921600;
    localparam int unsigned BAUD    = 57600;
    localparam int unsigned NCH     = 12;
    localparam int unsigned BIT_CYC = 16;
    localparam int K_FRAME = 1;
    localparam int K_CSUM  = 2;
    localparam int K_CHAN  = 3;
    localparam int K_OVR   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        cmd_ready = 1'b1;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_chan;
    logic [13:0] cmd_data;
    logic        err_frame, err_csum, err_chan, err_overrun;

    int          total = 0;
    int          bad = 0;
    int          err_q[$];
    logic [20:0] cmd_q[$];
    logic [7:0]  mbuf[$];
    bit          m_pending = 1'b0;
    bit          m_ready = 1'b1;

    uart_cmd_rx #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .NUM_INPUTS(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_chan(cmd_chan), .cmd_data(cmd_data),
        .err_frame(err_frame), .err_csum(err_csum), .err_chan(err_chan), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cmd_valid, cmd_op, cmd_chan, cmd_data, err_frame, err_csum, err_chan, err_overrun});
    endfunction

    // Reference model: collect bytes since the last header, judge the frame at its 4th byte.
    task automatic model_byte(input logic [7:0] b);
        logic [6:0] cs;
        if (b[7]) begin
            mbuf.delete();
            mbuf.push_back(b);
        end else if (mbuf.size() != 0) begin
            mbuf.push_back(b);
            if (mbuf.size() == 4) begin
                cs = mbuf[0][6:0] ^ mbuf[1][6:0] ^ mbuf[2][6:0];
                if (mbuf[3][6:0] != cs)              err_q.push_back(K_CSUM);
                else if (int'(mbuf[0][3:0]) >= NCH)  err_q.push_back(K_CHAN);
                else if (m_pending && !m_ready)      err_q.push_back(K_OVR);
                else begin
                    cmd_q.push_back({mbuf[0][6:4], mbuf[0][3:0], mbuf[1][6:0], mbuf[2][6:0]});
                    m_pending = !m_ready;
                end
                mbuf.delete();
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        RX = 1'b0;
        step(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            step(BIT_CYC);
        end
        RX = stop_bit;
        step(BIT_CYC);
        RX = 1'b1;
        step(gap);
    endtask

    task automatic tx(input logic [7:0] b);
        model_byte(b);
        send_byte(b, 1'b1, 3);
    endtask

    task automatic tx_badstop(input logic [7:0] b);
        mbuf.delete();
        err_q.push_back(K_FRAME);
        send_byte(b, 1'b0, 3);
    endtask

    task automatic pop_err(input int kind, input string name);
        if (err_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected actual=pulse required=none", name);
        end else begin
            check(name, 32'(kind), 32'(err_q.pop_front()));
        end
    endtask

    logic [20:0] prev_f = '0;
    logic        prev_v = 1'b0;
    logic        prev_hs = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (err_frame)   pop_err(K_FRAME, "err_frame");
            if (err_csum)    pop_err(K_CSUM, "err_csum");
            if (err_chan)    pop_err(K_CHAN, "err_chan");
            if (err_overrun) pop_err(K_OVR, "err_overrun");
            if (cmd_valid && prev_v && !prev_hs)
                check("cmd_hold", 32'({cmd_op, cmd_chan, cmd_data}), 32'(prev_f));
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cmd_unexpected actual=0x%0h required=none", {cmd_op, cmd_chan, cmd_data});
                end else begin
                    check("cmd_fields", 32'({cmd_op, cmd_chan, cmd_data}), 32'(cmd_q.pop_front()));
                end
            end
            prev_v  = cmd_valid;
            prev_hs = cmd_valid & cmd_ready;
            prev_f  = {cmd_op, cmd_chan, cmd_data};
        end
    end

    initial begin
        logic [7:0] h, d1, d2, c;
        int         r;

        step(3);
        check("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step(40);

        // Basic good frame, checksum error, channel range error.
        tx(8'h83); tx(8'h20); tx(8'h05); tx(8'h26);
        tx(8'h83); tx(8'h20); tx(8'h05); tx(8'h27);
        tx(8'h8C); tx(8'h01); tx(8'h02); tx(8'h0F);

        // Short low glitch must not produce a byte or an error.
        RX = 1'b0;
        step(4);
        RX = 1'b1;
        step(40);

        // Framing error mid-frame, stray data byte ignored, then a clean frame.
        tx(8'h85); tx(8'h11); tx_badstop(8'h22); tx(8'h33);
        tx(8'h85); tx(8'h11); tx(8'h22); tx(8'h36);

        // Overrun while the consumer stalls, then release.
        cmd_ready = 1'b0;
        m_ready   = 1'b0;
        tx(8'hA1); tx(8'h7F); tx(8'h01); tx(8'h5F);
        tx(8'hB4); tx(8'h02); tx(8'h03); tx(8'h35);
        step(5);
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_fields", 32'({cmd_op, cmd_chan, cmd_data}), 32'({3'd2, 4'd1, 7'h7F, 7'h01}));
        cmd_ready = 1'b1;
        m_ready   = 1'b1;
        m_pending = 1'b0;
        step(1);
        check("valid_drop", 32'(cmd_valid), 32'd0);
        step(10);

        // Resync on a new header mid-frame.
        tx(8'h81); tx(8'h10); tx(8'h92); tx(8'h00); tx(8'h00); tx(8'h12);

        // Reset in the middle of a byte and of a frame, with the line held low across release.
        tx(8'h85); tx(8'h01);
        RX = 1'b0;
        step(BIT_CYC);
        RX = 1'b1;
        step(BIT_CYC);
        RX = 1'b0;
        step(5);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", all_outs(), 32'd0);
        mbuf.delete();
        m_pending = 1'b0;
        step(4);
        rst_n = 1'b1;
        step(200);
        RX = 1'b1;
        step(20);
        tx(8'h02); tx(8'h03);
        tx(8'h9B); tx(8'h40); tx(8'h7F); tx(8'h24);

        // Random frames with occasional corruption, truncation, stray bytes and framing errors.
        for (int f = 0; f < 30; f++) begin
            r  = int'($urandom_range(0, 9));
            h  = {1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            d1 = {1'b0, 7'($urandom)};
            d2 = {1'b0, 7'($urandom)};
            c  = {1'b0, h[6:0] ^ d1[6:0] ^ d2[6:0]};
            if (r == 0) c = c ^ (8'd1 << $urandom_range(0, 6));
            if (r == 1) tx({1'b0, 7'($urandom)});
            tx(h);
            tx(d1);
            if (r == 2) continue;
            if (r == 3) begin
                tx_badstop(d2);
                continue;
            end
            tx(d2);
            tx(c);
        end

        step(300);
        check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        check("err_q_drained", 32'(err_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
